muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 30 +++
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake and HI/LO bus between the pipeline and the iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op;
  logic             sign;
  logic             annul;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hi_wdata;
  logic [WIDTH-1:0] lo_wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, sign, annul, a, b, hi_we, lo_we, hi_wdata, lo_wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, sign, annul, a, b, hi_we, lo_we, hi_wdata, lo_wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative restoring divider and shift-add multiplier feeding architectural HI/LO.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply instead.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  muldiv_unit_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  logic [1:0]         r_state, w_state_nx;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_rem, r_quo, r_dvs, r_a, r_hi, r_lo;
  logic               r_neg_q, r_neg_r, r_dbz, r_busy, r_done, r_dbz_o;

  logic               w_neg_a, w_neg_b, w_go, w_last;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_rem_nx, w_quo_nx;
  logic [WIDTH:0]     w_trial, w_sum;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;

  assign w_neg_a = bus.sign & bus.a[WIDTH-1];
  assign w_neg_b = bus.sign & bus.b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -bus.a : bus.a;
  assign w_mag_b = w_neg_b ? -bus.b : bus.b;
  assign w_go    = bus.start & ~bus.annul;
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  // Divide: r_rem is the partial remainder, r_quo shifts dividend out / quotient in.
  // Multiply: r_rem is the upper accumulator, r_quo shifts multiplier out / product in.
  assign w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
  assign w_sum   = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_dvs} : {(WIDTH+1){1'b0}});

  always_comb begin
    w_rem_nx = r_rem;
    w_quo_nx = r_quo;
    if (r_state == S_DIV) begin
      if (!w_trial[WIDTH]) begin
        w_rem_nx = w_trial[WIDTH-1:0];
        w_quo_nx = {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        w_rem_nx = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
        w_quo_nx = {r_quo[WIDTH-2:0], 1'b0};
      end
    end else if (r_state == S_MUL) begin
      w_rem_nx = w_sum[WIDTH:1];
      w_quo_nx = {w_sum[0], r_quo[WIDTH-1:1]};
    end
  end

  assign w_prod   = {w_rem_nx, w_quo_nx};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fprod, w_fres;
  assign w_fprod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
  assign w_fres  = (w_neg_a ^ w_neg_b) ? -w_fprod : w_fprod;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          if (bus.op) w_state_nx = S_DIV;
`ifndef MULDIV_FAST_MUL_EN
          else        w_state_nx = S_MUL;
`endif
        end
      end
      S_MUL, S_DIV: if (bus.annul || w_last) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Operand latch, iteration and HI/LO update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_a     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz_o <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_dbz_o <= 1'b0;
      r_busy  <= (w_state_nx != S_IDLE);
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
        if (bus.hi_we) r_hi <= bus.hi_wdata;
        if (bus.lo_we) r_lo <= bus.lo_wdata;
        if (w_go) begin
          r_neg_q <= w_neg_a ^ w_neg_b;
          r_neg_r <= w_neg_a;
          r_dbz   <= bus.op && (bus.b == '0);
          r_a     <= bus.a;
          r_rem   <= '0;
          r_quo   <= bus.op ? w_mag_a : w_mag_b;
          r_dvs   <= bus.op ? w_mag_b : w_mag_a;
`ifdef MULDIV_FAST_MUL_EN
          if (!bus.op) begin
            {r_hi, r_lo} <= w_fres;
            r_done       <= 1'b1;
          end
`endif
        end
      end else if (bus.annul) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
        r_rem <= w_rem_nx;
        r_quo <= w_quo_nx;
        if (w_last) begin
          r_done <= 1'b1;
          if (r_state == S_DIV) begin
            if (r_dbz) begin
              r_hi    <= r_a;
              r_lo    <= '1;
              r_dbz_o <= 1'b1;
            end else begin
              r_hi <= r_neg_r ? -w_rem_nx : w_rem_nx;
              r_lo <= r_neg_q ? -w_quo_nx : w_quo_nx;
            end
          end else begin
            {r_hi, r_lo} <= w_prod_s;
          end
        end
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz_o;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: arithmetic reference model, queue of expected results.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, C-style truncating signed divide.
  function automatic exp_t model(input bit op_i, input bit sg_i, input logic [W-1:0] a_i,
                                 input logic [W-1:0] b_i);
    exp_t e;
    logic [63:0] p;
    longint sa, sb, sq, sr;
    sa = longint'($signed(a_i));
    sb = longint'($signed(b_i));
    e.dbz = 1'b0;
    e.cyc = 0;
    if (!op_i) begin
      if (sg_i) p = 64'(sa * sb);
      else      p = {32'b0, a_i} * {32'b0, b_i};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b_i == 0) begin
      e.hi  = a_i;
      e.lo  = '1;
      e.dbz = 1'b1;
    end else if (sg_i) begin
      sq = sa / sb;
      sr = sa % sb;
      p  = 64'(sq);
      e.lo = p[31:0];
      p  = 64'(sr);
      e.hi = p[31:0];
    end else begin
      e.lo = a_i / b_i;
      e.hi = a_i % b_i;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (bus.done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'(bus.done), 64'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_hi", 64'(bus.hi), 64'(e.hi));
        chk("res_lo", 64'(bus.lo), 64'(e.lo));
        chk("res_dbz", 64'(bus.div_by_zero), 64'(e.dbz));
        chk("res_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (bus.div_by_zero) begin
      chk("dbz_without_done", 64'(bus.div_by_zero), 64'(0));
    end
  end

  // Called just after a rising edge; leaves the caller one cycle later, after start drops.
  task automatic issue(input bit op_i, input bit sg_i, input logic [W-1:0] a_i,
                       input logic [W-1:0] b_i, input bit push, input bit wr);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.sign  = sg_i;
    bus.a     = a_i;
    bus.b     = b_i;
    if (wr) begin
      bus.hi_we    = 1'b1;
      bus.lo_we    = 1'b1;
      bus.hi_wdata = $urandom;
      bus.lo_wdata = $urandom;
    end
    if (push) begin
      e = model(op_i, sg_i, a_i, b_i);
      e.cyc = cyc + (op_i ? DIV_LAT : MUL_LAT);
      q.push_back(e);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.op    = 1'($urandom);
    bus.sign  = 1'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((bus.busy || q.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_reached", 64'(n >= 100), 64'(0));
  endtask

  task automatic direct_write(input logic [W-1:0] h, input logic [W-1:0] l);
    bus.hi_we = 1'b1; bus.hi_wdata = h;
    bus.lo_we = 1'b1; bus.lo_wdata = l;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    bus.start = 0; bus.op = 0; bus.sign = 0; bus.annul = 0;
    bus.a = 0; bus.b = 0;
    bus.hi_we = 0; bus.lo_we = 0; bus.hi_wdata = 0; bus.lo_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_hi", 64'(bus.hi), 64'(0));
    chk("rst_lo", 64'(bus.lo), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_dbz", 64'(bus.div_by_zero), 64'(0));

    // Unsigned 100/7 with busy window check.
    issue(1'b1, 1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
    @(negedge clk);
    chk("div_busy_c1", 64'(bus.busy), 64'(1));
    repeat (31) @(negedge clk);
    chk("div_busy_c32", 64'(bus.busy), 64'(1));
    @(negedge clk);
    chk("div_busy_c33", 64'(bus.busy), 64'(0));
    chk("div100_7_lo", 64'(bus.lo), 64'(14));
    chk("div100_7_hi", 64'(bus.hi), 64'(2));
    @(posedge clk); #1;
    wait_done();

    issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    wait_done();
    chk("sdiv_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
    chk("sdiv_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);

    issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    wait_done();
    chk("smul_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    chk("smul_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFE);

    issue(1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 1'b0);
    wait_done();
    chk("dbz_hi", 64'(bus.hi), 64'(5));
    chk("dbz_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFF);

    issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_done();
    chk("minneg_lo", 64'(bus.lo), 64'h0000_0000_8000_0000);
    chk("minneg_hi", 64'(bus.hi), 64'(0));

    // Annul mid-divide; start and direct write while busy are ignored.
    direct_write(32'h11, 32'h22);
    issue(1'b1, 1'b0, 32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.op = 1'b1; bus.hi_we = 1'b1; bus.hi_wdata = 32'hDEAD;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    bus.annul = 1'b1;
    @(posedge clk); #1;
    bus.annul = 1'b0;
    chk("annul_busy", 64'(bus.busy), 64'(0));
    chk("annul_hi", 64'(bus.hi), 64'h11);
    chk("annul_lo", 64'(bus.lo), 64'h22);
    repeat (40) begin @(posedge clk); #1; end
    chk("annul_hi_late", 64'(bus.hi), 64'h11);

    // Annul in IDLE blocks a simultaneous start.
    bus.annul = 1'b1;
    issue(1'b1, 1'b0, 32'd9, 32'd2, 1'b0, 1'b0);
    bus.annul = 1'b0;
    chk("idle_annul_busy", 64'(bus.busy), 64'(0));
    repeat (40) begin @(posedge clk); #1; end

    // Direct write together with start: the result lands later and wins.
    issue(1'b1, 1'b0, 32'd77, 32'd10, 1'b1, 1'b1);
    wait_done();

    // Reset mid-divide overrides a concurrent start.
    direct_write(32'h33, 32'h44);
    chk("pre_rst_hi", 64'(bus.hi), 64'h33);
    issue(1'b1, 1'b0, 32'd500, 32'd9, 1'b0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1; bus.start = 1'b1; bus.op = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    chk("mrst_hi", 64'(bus.hi), 64'(0));
    chk("mrst_lo", 64'(bus.lo), 64'(0));
    chk("mrst_busy", 64'(bus.busy), 64'(0));
    chk("mrst_done", 64'(bus.done), 64'(0));
    repeat (40) begin @(posedge clk); #1; end

    // Randomized operations against the model.
    for (int i = 0; i < 48; i++) begin
      case ($urandom % 8)
        0: ra = 32'h8000_0000;
        1: ra = $urandom % 256;
        default: ra = $urandom;
      endcase
      case ($urandom % 8)
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom % 16;
        default: rb = $urandom;
      endcase
      issue(1'($urandom), 1'($urandom), ra, rb, 1'b1, ($urandom % 4) == 0);
      wait_done();
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
